// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 8N1-style UART receiver with mid-bit sampling, framing error and break handling
module uart_rx_deser #(
  parameter int DW = 8,
  parameter int SLOOP_MAX = 100
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          RX,
  output logic [DW-1:0] DOUT,
  output logic          VALID,
  output logic          FERR,
  output logic          BUSY
);
  localparam int CW = $clog2(SLOOP_MAX);
  localparam int BW = $clog2(DW + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(SLOOP_MAX / 2 - 1);
  localparam logic [CW-1:0] BIT_M1 = CW'(SLOOP_MAX - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state_q, state_d;
  logic s1_q, rxs_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bitidx_q, bitidx_d;
  logic [DW-1:0] shreg_q, shreg_d, dout_q, dout_d;
  logic valid_q, valid_d, ferr_q, ferr_d, busy_q, busy_d;
  assign DOUT = dout_q;
  assign VALID = valid_q;
  assign FERR = ferr_q;
  assign BUSY = busy_q;
  // next-state: start qualification at mid start bit, data/stop sampled once per bit period
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bitidx_d = bitidx_q;
    shreg_d = shreg_q;
    dout_d = dout_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = rxs_q ? IDLE : START;
      end
      START: if (cnt_q == HALF_M1) begin
        cnt_d = '0;
        bitidx_d = '0;
        state_d = rxs_q ? IDLE : DATA;
      end
      DATA: if (cnt_q == BIT_M1) begin
        cnt_d = '0;
        shreg_d = {rxs_q, shreg_q[DW-1:1]};
        bitidx_d = bitidx_q + 1'b1;
        state_d = (bitidx_q == LAST_BIT) ? STOP : DATA;
      end
      STOP: if (cnt_q == BIT_M1) begin
        cnt_d = '0;
        state_d = rxs_q ? IDLE : BREAK;
        valid_d = rxs_q;
        ferr_d = !rxs_q;
        dout_d = rxs_q ? shreg_q : dout_q;
      end
      BREAK: begin
        cnt_d = '0;
        state_d = rxs_q ? IDLE : BREAK;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end
  // synchroniser and all registered state/outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q <= 1'b1;
      rxs_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      bitidx_q <= '0;
      shreg_q <= '0;
      dout_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      s1_q <= RX;
      rxs_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      bitidx_q <= bitidx_d;
      shreg_q <= shreg_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- UART receive front end: asynchronous RX pin in, DW-bit parallel byte plus a one-cycle valid strobe out.
- Sits directly upstream of the command matchers (the "VER" version-query responder and similar) and feeds their rxvalid/RXDOT inputs.
- Frame format is 8N1-style: 1 start bit, DW data bits LSB first, 1 stop bit, no parity.
- SLOOP_MAX clocks per bit; this matches the transmit side so one parameter sets the link rate.

Parameters:
- DW, 8, data bits per frame.
- SLOOP_MAX, 100, clock cycles per bit. Legal range is >= 4. HALF = SLOOP_MAX/2, using integer division.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous to CLK, active-high.
- RX  in  1  serial line, asynchronous to CLK, idle high.
- DOUT  out  DW  last correctly received byte; held until the next good frame.
- VALID  out  1  one-cycle pulse when DOUT is updated.
- FERR  out  1  one-cycle pulse on framing error (stop bit sampled low).
- BUSY  out  1  high whenever state != IDLE.

Behaviour:
- Synchroniser: 2-flop chain RX -> s1 -> rxs. Both flops reset to 1. All decisions use rxs only.
- Counters:
  - cnt is $clog2(SLOOP_MAX) bits and reset to 0.
  - bitidx is $clog2(DW+1) bits.
  - shreg is DW bits.
- Reset values: DOUT=0, VALID=0, FERR=0, BUSY=0, state=IDLE, cnt=0, bitidx=0, shreg=0.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rxs==0 -> START with cnt=0.
  - IDLE is only entered with the line high, so this is a level check.
- START:
  - cnt increments each cycle.
  - At cnt==HALF-1 (mid start bit), sample rxs.
  - rxs==0 -> DATA, cnt=0, bitidx=0.
  - rxs==1 (glitch) -> IDLE, with no output activity.
- DATA:
  - cnt increments; at cnt==SLOOP_MAX-1, shreg <= {rxs, shreg[DW-1:1]} (LSB first), cnt=0, bitidx++.
  - After the DW-th sample -> STOP.
- STOP, at cnt==SLOOP_MAX-1, sample rxs:
  - rxs==1: DOUT <= shreg, VALID=1 on the following cycle only, -> IDLE. Return happens at mid stop bit, so a start bit immediately following one stop bit is caught.
  - rxs==0: FERR=1 on the following cycle only, DOUT unchanged, -> BREAK.
- BREAK: stay until rxs==1, then -> IDLE. A held-low line gives exactly one FERR and no further frames.
- Timing: with START entered at edge E0:
  - data bit k (k=1..DW) is sampled at edge E0+HALF+k*SLOOP_MAX;
  - stop bit is sampled at E0+HALF+(DW+1)*SLOOP_MAX;
  - VALID/FERR are high in the cycle after the stop sample.
  - RX pin to START entry is 2-3 cycles (synchroniser).
- VALID and FERR are never high together. Each is high for at most one cycle per frame.
- RST mid-frame:
  - immediate return to reset values; the partial byte is discarded and there is no VALID.
  - If the line is still mid-frame when RST drops, a low data bit may start a false frame. This is permitted; upstream guarantees idle after reset.
- Tolerance: mid-bit sampling accepts a transmitter clock error of up to about ±4% at DW=8.

Test Plan (SLOOP_MAX=16, DW=8 unless noted):
1. Single frame 0x56 ('V') with exact 16-clock bits -> DOUT=0x56, VALID high for exactly 1 cycle, 8+144=152 cycles after START entry. FERR stays 0. BUSY returns to 0 on the VALID cycle.
2. Back-to-back 'V','E','R',0x0D,0x0A, each with a single stop bit and no idle gap -> five VALID pulses carrying DOUT=0x56,0x45,0x52,0x0D,0x0A in order. No FERR.
3. RX low glitch of 3 cycles, then high -> BUSY high for about 8 cycles, then IDLE. No VALID, no FERR, DOUT unchanged.
4. Frame 0x00 with stop bit low and the line then held low for 30 bit times, then high, then frame 0xA5 -> exactly one FERR pulse, no VALID for the break, then DOUT=0xA5 with one VALID.
5. RST asserted for 1 cycle after 4 data bits of 0xFF, line then idle for 2 bit times, then frame 0x3C -> all outputs 0 after reset; next VALID carries DOUT=0x3C. No VALID for the aborted frame.
6. Transmitter bit period 17 clocks (+6%) then 15 clocks (-6%), frame 0x55 each, with SLOOP_MAX=100 variant at 104/96 clocks (+/-4%) -> 0x55 received with VALID in the ±4% cases. The 16-clock-parameter ±6% results are recorded, not required.
